// File: rtl/fifo_paced_reader.sv
// Paced reader for the fifo read port: pops one word per DIV+2 cycles while enabled and not empty.
// Latency: en/empty seen at edge k -> rd in cycle k+1 -> data_out/pop_tick at edge k+2.
// Backpressure: never reads while empty; a flush during POP aborts the pop. Option: PACED_READER_COUNT_EN.
module fifo_paced_reader #(
    parameter int B     = 3,
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         empty,
    input  logic [B-1:0] r_data,
    output logic         rd,
    output logic [B-1:0] data_out,
    output logic         data_valid,
    output logic         pop_tick
`ifdef PACED_READER_COUNT_EN
    ,
    output logic [7:0]   rd_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [B-1:0]     data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             pop_tick_q, pop_tick_d;
    logic             pop_ok;

    // The FIFO consumes the head on the same edge we capture it.
    assign pop_ok = (state_q == S_POP) && !empty;
    assign rd     = pop_ok;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        pop_tick_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && !empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (pop_ok) begin
                    data_out_d   = r_data;
                    data_valid_d = 1'b1;
                    pop_tick_d   = 1'b1;
                    cnt_d        = RELOAD;
                    state_d      = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // en is deliberately ignored so the pacing interval is never cut short.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            pop_tick_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            pop_tick_q   <= pop_tick_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign pop_tick   = pop_tick_q;

`ifdef PACED_READER_COUNT_EN
    logic [7:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (pop_ok) begin
            rd_count_d = rd_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= 8'd0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_paced_reader.sv
// Bench for fifo_paced_reader: queue-based FIFO model plus a scoreboard of written words,
// checked by a negedge monitor against the pacing and capture rules.
module tb_fifo_paced_reader;

    localparam int B   = 3;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         empty;
    logic [B-1:0] r_data;
    logic         rd;
    logic [B-1:0] data_out;
    logic         data_valid;
    logic         pop_tick;
`ifdef PACED_READER_COUNT_EN
    logic [7:0]   rd_count;
`endif

    // FIFO model driven by the bench
    logic         wr_en;
    logic [B-1:0] wr_dat;
    logic         flush;
    logic [B-1:0] mem [0:1023];
    logic [9:0]   wp = 10'd0;
    logic [9:0]   rp = 10'd0;

    int checks = 0;
    int errors = 0;

    logic [B-1:0] exp_q[$];
    int           rd_hist[$];
    int           cyc = 0;
    int           last_rd = 0;
    bit           have_last = 1'b0;
    logic         prev_rd = 1'b0;
    logic [B-1:0] model_dout = '0;
    logic         model_valid = 1'b0;
    logic [7:0]   model_cnt = 8'd0;

    always #5 clk = ~clk;

    fifo_paced_reader #(.B(B), .DIV(DIV), .DIV_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .empty      (empty),
        .r_data     (r_data),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pop_tick   (pop_tick)
`ifdef PACED_READER_COUNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    assign empty  = (wp == rp) || flush;
    assign r_data = mem[rp];

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_dat;
            wp      <= wp + 10'd1;
        end
        if (rd) begin
            rp <= rp + 10'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [B-1:0] w);
        @(posedge clk);
        #1;
        wr_en  = 1'b1;
        wr_dat = w;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_rd(input int maxc, input string nm);
        int i;
        i = 0;
        while (!rd && i < maxc) begin
            tick(1);
            i++;
        end
        chk(nm, {31'd0, rd}, 32'd1);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick(1);
            t++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    // Monitor: every written word must appear on data_out, in order, once per pop_tick.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            model_dout  = '0;
            model_valid = 1'b0;
            model_cnt   = 8'd0;
            prev_rd     = 1'b0;
            have_last   = 1'b0;
        end else begin
            chk("no_rd_when_empty", {31'd0, rd & empty}, 32'd0);
            chk("rd_not_back_to_back", {31'd0, rd & prev_rd}, 32'd0);
            chk("tick_follows_rd", {31'd0, pop_tick}, {31'd0, prev_rd});
            if (pop_tick) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_has_word", 32'd0, 32'd1);
                end else begin
                    model_dout = exp_q.pop_front();
                end
                model_valid = 1'b1;
                model_cnt   = model_cnt + 8'd1;
            end
            chk("data_out", {29'd0, data_out}, {29'd0, model_dout});
            chk("data_valid", {31'd0, data_valid}, {31'd0, model_valid});
`ifdef PACED_READER_COUNT_EN
            chk("rd_count", {24'd0, rd_count}, {24'd0, model_cnt});
`endif
            if (rd) begin
                if (have_last) begin
                    chk("rd_gap_min", {31'd0, (cyc - last_rd) >= DIV + 2}, 32'd1);
                end
                last_rd   = cyc;
                have_last = 1'b1;
                rd_hist.push_back(cyc);
            end
            prev_rd = rd;
        end
    end

    initial begin
        int n0;
        reset  = 1'b1;
        en     = 1'b0;
        wr_en  = 1'b0;
        wr_dat = '0;
        flush  = 1'b0;
        #3;
        chk("reset_rd", {31'd0, rd}, 32'd0);
        chk("reset_data_out", {29'd0, data_out}, 32'd0);
        chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_pop_tick", {31'd0, pop_tick}, 32'd0);
        tick(2);
        reset = 1'b0;

        // Empty FIFO with en=1: nothing happens
        en = 1'b1;
        n0 = rd_hist.size();
        tick(50);
        chk("empty_no_rd", rd_hist.size() - n0, 0);
        chk("empty_valid_low", {31'd0, data_valid}, 32'd0);
        chk("empty_dout_zero", {29'd0, data_out}, 32'd0);

        // Preloaded 5,2,7: three pops, DIV+2 apart
        en = 1'b0;
        push(3'd5);
        push(3'd2);
        push(3'd7);
        n0 = rd_hist.size();
        en = 1'b1;
        tick(40);
        chk("preload_rd_count", rd_hist.size() - n0, 3);
        if (rd_hist.size() - n0 == 3) begin
            chk("preload_gap1", rd_hist[n0+1] - rd_hist[n0], DIV + 2);
            chk("preload_gap2", rd_hist[n0+2] - rd_hist[n0+1], DIV + 2);
        end
        chk("preload_fifo_empty", {31'd0, wp == rp}, 32'd1);
        chk("preload_last_word", {29'd0, data_out}, 32'd7);

        // en dropped during WAIT: interval completes, no further pop until en returns
        en = 1'b0;
        push(3'd3);
        push(3'd6);
        en = 1'b1;
        wait_rd(4, "endrop_first_rd");
        tick(1);
        en = 1'b0;
        n0 = rd_hist.size();
        tick(15);
        chk("endrop_no_rd", rd_hist.size() - n0, 0);
        chk("endrop_word_kept", {29'd0, data_out}, 32'd3);
        en = 1'b1;
        wait_rd(2, "endrop_repop_within_2");
        tick(1);
        chk("endrop_second_word", {29'd0, data_out}, 32'd6);
        chk("endrop_second_tick", {31'd0, pop_tick}, 32'd1);

        // Async reset mid-WAIT
        push(3'd1);
        wait_rd(6, "rst_rd_before");
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rd", {31'd0, rd}, 32'd0);
        chk("async_rst_data_out", {29'd0, data_out}, 32'd0);
        chk("async_rst_valid", {31'd0, data_valid}, 32'd0);
        chk("async_rst_tick", {31'd0, pop_tick}, 32'd0);
        tick(2);
        reset = 1'b0;
        push(3'd4);
        wait_rd(4, "rst_rd_after");
        tick(1);
        chk("rst_after_word", {29'd0, data_out}, 32'd4);
        chk("rst_after_tick", {31'd0, pop_tick}, 32'd1);

        // Flush exactly over the POP cycle
        tick(8);
        en = 1'b0;
        push(3'd1);
        tick(10);
        en = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_rd_low", {31'd0, rd}, 32'd0);
        tick(1);
        chk("flush_no_tick", {31'd0, pop_tick}, 32'd0);
        chk("flush_dout_held", {29'd0, data_out}, 32'd4);
        flush = 1'b0;
        tick(1);
        chk("flush_back_to_idle_repop", {31'd0, rd}, 32'd1);
        tick(2);
        chk("flush_word_later", {29'd0, data_out}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                wr_en  = 1'b1;
                wr_dat = B'($urandom);
                exp_q.push_back(wr_dat);
            end else begin
                wr_en = 1'b0;
            end
            tick(1);
        end
        wr_en = 1'b0;
        en    = 1'b1;
        drain("random_drain");
        tick(DIV + 3);

`ifdef PACED_READER_COUNT_EN
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 260; i++) begin
            push((i % 2) ? 3'd5 : 3'd2);
        end
        drain("count_drain");
        tick(3);
        chk("count_wrap", {24'd0, rd_count}, 32'd4);
        chk("count_last_word", {29'd0, data_out}, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
